simple_uart_wb_ctrl: RTL and testbench
======================================

Name: simple_uart_wb_ctrl

Overview:
- Wishbone master that sequences one simple_uart instance on behalf of byte-stream clients.
- Programs the baud divider after reset and on request.
- Moves bytes from a TX stream into the UART TXCHAR register when the UART TX FIFO has space.
- Drains RXCHAR into an RX stream when the UART RX FIFO is non-empty, so firmware-free paths (e.g. a debug console bridge) can use the UART without a CPU.

Parameters:
- CLKDIV_INIT, 16'd0: divider written to UART register 0 after reset.
- WB_TIMEOUT, 16'd255: max cycles a bus cycle may wait for ack before abort (must be >= 2).
- SETTLE, 4'd2: cycles after a TXCHAR write / RXCHAR read before tx_int_i / rx_int_i are trusted again.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  3  UART register address (0 CLKDIV, 3 TXCHAR, 4 RXCHAR)
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data, valid while wb_ack_i=1
- wb_ack_i  in  1  Wishbone acknowledge
- tx_int_i  in  1  UART TX FIFO not full
- rx_int_i  in  1  UART RX FIFO not empty
- clkdiv_i  in  16  new divider value
- clkdiv_stb_i  in  1  one-cycle request to write clkdiv_i
- tx_tdata  in  8  byte to transmit
- tx_tvalid  in  1
- tx_tready  out  1
- rx_tdata  out  8  received byte
- rx_tvalid  out  1
- rx_tready  in  1
- busy_o  out  1  state != IDLE or any pending request
- err_o  out  1  one-cycle pulse on bus timeout

Behaviour:
- Reset values: all wb_* outputs 0, tx_tready 0, rx_tvalid 0, rx_tdata 0, busy_o 1, err_o 0.
- On the first cycle after reset, state = INIT_DIV.
- Bus cycle:
  - cyc/stb/we/adr/dat are driven in the same cycle and held stable until the cycle where wb_ack_i=1.
  - cyc/stb drop in the cycle after ack, so two cycles is the minimum per access.
  - Read data is captured from wb_dat_i[7:0] on the ack cycle.
- Timeout:
  - A counter runs while stb is high.
  - When it reaches WB_TIMEOUT without ack, cyc/stb drop, err_o pulses one cycle, and state goes to IDLE.
  - A timed-out TXCHAR write keeps its byte held for retry.
  - A timed-out RXCHAR read produces no output byte.
- TX holding register (1 entry):
  - tx_tready = ~tx_hold_valid (low in reset).
  - A byte is accepted on tx_tvalid & tx_tready.
  - tx_hold_valid clears on the ack of the TXCHAR write.
- RX holding register (1 entry):
  - rx_tvalid is set with rx_tdata on the ack of a RXCHAR read.
  - It clears on rx_tvalid & rx_tready.
- States:
  - INIT_DIV: write CLKDIV_INIT to adr 0 -> IDLE on ack/timeout.
  - IDLE: select a request by priority:
    1. DIV_WR, if a divider request is pending.
    2. TX_WR and RX_RD under round-robin. Last-served flag starts on RX, so TX wins the first tie.
       - TX eligible: tx_hold_valid & tx_int_i & settle_cnt==0.
       - RX eligible: ~rx_tvalid & rx_int_i & settle_cnt==0.
  - DIV_WR: write latched divider to adr 0, dat_o[31:16]=0 -> IDLE.
  - TX_WR: write {24'b0, tx_hold} to adr 3. On ack, load settle_cnt=SETTLE -> IDLE.
  - RX_RD: read adr 4. On ack, load settle_cnt=SETTLE -> IDLE.
  - settle_cnt decrements to 0 every cycle independent of state.
- clkdiv_stb_i:
  - Latches clkdiv_i and sets a pending flag in any state, including mid-access; a later strobe overwrites the value.
  - The pending flag clears when DIV_WR starts.
  - A strobe during INIT_DIV is serviced after INIT_DIV completes.
- No new access starts in the cycle cyc drops; IDLE lasts at least one cycle between accesses.
- busy_o is combinational: (state!=IDLE) | div_pending | tx_hold_valid.
- Reset mid-access: wb_cyc_o/stb_o drop on the next edge, holding registers clear, and state returns to INIT_DIV.

Test Plan:
- Reset release with a slave acking 1 cycle after stb, CLKDIV_INIT=16'd27 -> single write adr=0, dat=27; busy_o falls on cycle 4 after reset release.
- tx_int_i=1, stream bytes 0x41,0x42 back-to-back -> two TXCHAR writes (adr=3, dat=0x41 then 0x42) separated by >= SETTLE+1 idle cycles; tx_tready low between accept and ack.
- rx_int_i=1, slave returns 0x5A with rx_tready=0 -> one read, rx_tvalid=1 with rx_tdata=0x5A, no further RXCHAR read until rx_tready handshake.
- TX byte held and rx_int_i=1 simultaneously, both ints stay high -> accesses alternate TX, RX, TX, ...; clkdiv_stb_i with 16'd100 mid-TX write -> next access is adr 0 dat 100.
- Slave never acks on TXCHAR, WB_TIMEOUT=10 -> stb low after 10 cycles, err_o single pulse, byte retried on next eligible cycle.
- tx_int_i=0 with tx byte held -> no bus activity, tx_tready=0; assert rst_i during an RX read -> cyc low next cycle, rx_tvalid=0, INIT_DIV rerun.

Source files
------------

// File: rtl/simple_uart_wb_ctrl_if.sv
// Wishbone bus between simple_uart_wb_ctrl (master) and a simple_uart
// register file (slave).
//   wb_cyc_o / wb_stb_o : bus cycle and strobe
//   wb_we_o             : 1 = write, 0 = read
//   wb_adr_o [2:0]      : UART register (0 CLKDIV, 3 TXCHAR, 4 RXCHAR)
//   wb_dat_o [31:0]     : write data
//   wb_dat_i [31:0]     : read data, valid while wb_ack_i is high
//   wb_ack_i            : slave acknowledge
interface simple_uart_wb_ctrl_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [2:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/simple_uart_wb_ctrl.sv
// Wishbone master that runs one simple_uart without a CPU: programs the baud
// divider after reset and on request, moves bytes from a TX stream into
// TXCHAR and drains RXCHAR into an RX stream.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   wb                      : Wishbone master port (see simple_uart_wb_ctrl_if)
//   tx_int_i / rx_int_i     : UART TX FIFO not full / RX FIFO not empty
//   clkdiv_i, clkdiv_stb_i  : new divider value and one-cycle write request
//   tx_tdata/tvalid/tready  : byte stream to transmit (1-entry holding reg)
//   rx_tdata/tvalid/tready  : received byte stream (1-entry holding reg)
//   busy_o                  : not idle, or a divider/TX request is pending
//   err_o                   : one-cycle pulse when a bus access times out
module simple_uart_wb_ctrl #(
  parameter logic [15:0] CLKDIV_INIT = 16'd0,
  parameter logic [15:0] WB_TIMEOUT  = 16'd255,
  parameter logic [3:0]  SETTLE      = 4'd2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  simple_uart_wb_ctrl_if.master       wb,
  input  logic                        tx_int_i,
  input  logic                        rx_int_i,
  input  logic [15:0]                 clkdiv_i,
  input  logic                        clkdiv_stb_i,
  input  logic [7:0]                  tx_tdata,
  input  logic                        tx_tvalid,
  output logic                        tx_tready,
  output logic [7:0]                  rx_tdata,
  output logic                        rx_tvalid,
  input  logic                        rx_tready,
  output logic                        busy_o,
  output logic                        err_o
);

  typedef enum logic [2:0] {
    ST_INIT_DIV,
    ST_IDLE,
    ST_DIV_WR,
    ST_TX_WR,
    ST_RX_RD
  } state_t;

  localparam logic [2:0] ADR_CLKDIV = 3'd0;
  localparam logic [2:0] ADR_TXCHAR = 3'd3;
  localparam logic [2:0] ADR_RXCHAR = 3'd4;

  state_t      state_reg;
  logic        cyc_reg, stb_reg, we_reg;
  logic [2:0]  adr_reg;
  logic [31:0] dat_reg;
  logic [15:0] tmo_cnt_reg;
  logic        err_reg;
  logic [3:0]  settle_cnt_reg;
  logic [15:0] div_reg;
  logic        div_pending_reg;
  logic [7:0]  tx_hold_reg;
  logic        tx_hold_valid_reg, tx_hold_valid_next;
  logic        tx_ready_reg;
  logic [7:0]  rx_data_reg;
  logic        rx_valid_reg;
  logic        last_rx_reg;   // last round-robin winner was RX

  logic access_done, access_tmo;
  logic tx_elig, rx_elig, pick_tx, tx_accept, tx_ack;
  logic unused_dat;

  assign access_done = stb_reg & wb.wb_ack_i;
  // The counter starts at 0 on the first strobe cycle, so stb stays high for
  // exactly WB_TIMEOUT cycles before an abort.
  assign access_tmo  = stb_reg & ~wb.wb_ack_i & (tmo_cnt_reg == WB_TIMEOUT - 16'd1);

  assign tx_elig   = tx_hold_valid_reg & tx_int_i & (settle_cnt_reg == 4'd0);
  assign rx_elig   = ~rx_valid_reg & rx_int_i & (settle_cnt_reg == 4'd0);
  assign pick_tx   = tx_elig & (~rx_elig | last_rx_reg);
  assign tx_accept = tx_tvalid & tx_ready_reg;
  assign tx_ack    = (state_reg == ST_TX_WR) & access_done;

  // Accept and TXCHAR ack never coincide: ready is low while a byte is held.
  always_comb begin
    tx_hold_valid_next = tx_hold_valid_reg;
    if (tx_accept)   tx_hold_valid_next = 1'b1;
    else if (tx_ack) tx_hold_valid_next = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg         <= ST_INIT_DIV;
      cyc_reg           <= 1'b0;
      stb_reg           <= 1'b0;
      we_reg            <= 1'b0;
      adr_reg           <= 3'd0;
      dat_reg           <= 32'd0;
      tmo_cnt_reg       <= 16'd0;
      err_reg           <= 1'b0;
      settle_cnt_reg    <= 4'd0;
      div_reg           <= 16'd0;
      div_pending_reg   <= 1'b0;
      tx_hold_reg       <= 8'd0;
      tx_hold_valid_reg <= 1'b0;
      tx_ready_reg      <= 1'b0;
      rx_data_reg       <= 8'd0;
      rx_valid_reg      <= 1'b0;
      last_rx_reg       <= 1'b1;
    end else begin
      err_reg     <= 1'b0;
      tmo_cnt_reg <= stb_reg ? tmo_cnt_reg + 16'd1 : 16'd0;
      if (settle_cnt_reg != 4'd0) settle_cnt_reg <= settle_cnt_reg - 4'd1;

      if (clkdiv_stb_i) begin
        div_reg         <= clkdiv_i;
        div_pending_reg <= 1'b1;
      end

      tx_hold_valid_reg <= tx_hold_valid_next;
      tx_ready_reg      <= ~tx_hold_valid_next;
      if (tx_accept) tx_hold_reg <= tx_tdata;

      if (rx_valid_reg && rx_tready) rx_valid_reg <= 1'b0;

      if (stb_reg) begin
        // Access in flight: hold every bus output until ack or timeout.
        if (access_done || access_tmo) begin
          cyc_reg   <= 1'b0;
          stb_reg   <= 1'b0;
          we_reg    <= 1'b0;
          adr_reg   <= 3'd0;
          dat_reg   <= 32'd0;
          err_reg   <= access_tmo;
          state_reg <= ST_IDLE;
          if (access_done && state_reg == ST_TX_WR) begin
            settle_cnt_reg <= SETTLE;
          end
          if (access_done && state_reg == ST_RX_RD) begin
            rx_data_reg    <= wb.wb_dat_i[7:0];
            rx_valid_reg   <= 1'b1;
            settle_cnt_reg <= SETTLE;
          end
        end
      end else begin
        case (state_reg)
          ST_INIT_DIV: begin
            cyc_reg <= 1'b1;
            stb_reg <= 1'b1;
            we_reg  <= 1'b1;
            adr_reg <= ADR_CLKDIV;
            dat_reg <= {16'd0, CLKDIV_INIT};
          end
          ST_IDLE: begin
            if (div_pending_reg) begin
              state_reg       <= ST_DIV_WR;
              cyc_reg         <= 1'b1;
              stb_reg         <= 1'b1;
              we_reg          <= 1'b1;
              adr_reg         <= ADR_CLKDIV;
              dat_reg         <= {16'd0, div_reg};
              // A strobe landing in this same cycle queues another write.
              div_pending_reg <= clkdiv_stb_i;
            end else if (pick_tx) begin
              state_reg   <= ST_TX_WR;
              cyc_reg     <= 1'b1;
              stb_reg     <= 1'b1;
              we_reg      <= 1'b1;
              adr_reg     <= ADR_TXCHAR;
              dat_reg     <= {24'd0, tx_hold_reg};
              last_rx_reg <= 1'b0;
            end else if (rx_elig) begin
              state_reg   <= ST_RX_RD;
              cyc_reg     <= 1'b1;
              stb_reg     <= 1'b1;
              we_reg      <= 1'b0;
              adr_reg     <= ADR_RXCHAR;
              dat_reg     <= 32'd0;
              last_rx_reg <= 1'b1;
            end
          end
          // Access states always have stb high; recover to IDLE otherwise.
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign unused_dat  = ^wb.wb_dat_i[31:8];

  assign wb.wb_cyc_o = cyc_reg;
  assign wb.wb_stb_o = stb_reg;
  assign wb.wb_we_o  = we_reg;
  assign wb.wb_adr_o = adr_reg;
  assign wb.wb_dat_o = dat_reg;

  assign tx_tready = tx_ready_reg;
  assign rx_tdata  = rx_data_reg;
  assign rx_tvalid = rx_valid_reg;
  assign err_o     = err_reg;
  assign busy_o    = (state_reg != ST_IDLE) | div_pending_reg | tx_hold_valid_reg;

endmodule

// File: tb/tb_simple_uart_wb_ctrl.sv
module tb_simple_uart_wb_ctrl;
  localparam logic [15:0] P_CLKDIV = 16'd27;
  localparam logic [15:0] P_TMO    = 16'd10;
  localparam logic [3:0]  P_SETTLE = 4'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_int = 1'b0;
  logic        rx_int;
  logic [15:0] clkdiv = 16'd0;
  logic        clkdiv_stb = 1'b0;
  logic [7:0]  tx_tdata = 8'd0;
  logic        tx_tvalid = 1'b0;
  logic        tx_tready;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid;
  logic        rx_tready = 1'b0;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  simple_uart_wb_ctrl_if wb_bus();

  simple_uart_wb_ctrl #(
    .CLKDIV_INIT (P_CLKDIV),
    .WB_TIMEOUT  (P_TMO),
    .SETTLE      (P_SETTLE)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wb           (wb_bus),
    .tx_int_i     (tx_int),
    .rx_int_i     (rx_int),
    .clkdiv_i     (clkdiv),
    .clkdiv_stb_i (clkdiv_stb),
    .tx_tdata     (tx_tdata),
    .tx_tvalid    (tx_tvalid),
    .tx_tready    (tx_tready),
    .rx_tdata     (rx_tdata),
    .rx_tvalid    (rx_tvalid),
    .rx_tready    (rx_tready),
    .busy_o       (busy),
    .err_o        (err)
  );

  typedef struct packed {
    logic        we;
    logic [2:0]  adr;
    logic [31:0] dat;
  } bus_t;

  bus_t       exp_bus_q[$];
  logic [7:0] exp_rx_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART register slave: registered ack one cycle after stb, RX FIFO modelled
  // as a byte count with an incrementing data pattern.
  logic       ack_en = 1'b1;
  logic [7:0] rx_byte = 8'h5A;
  int         rx_avail = 0;
  logic       rx_set_stb = 1'b0;
  int         rx_set_val = 0;

  always @(posedge clk) begin
    if (rst) wb_bus.wb_ack_i <= 1'b0;
    else     wb_bus.wb_ack_i <= ack_en & wb_bus.wb_cyc_o & wb_bus.wb_stb_o & ~wb_bus.wb_ack_i;
    if (rx_set_stb) rx_avail <= rx_set_val;
    else if (wb_bus.wb_ack_i && wb_bus.wb_stb_o && !wb_bus.wb_we_o && wb_bus.wb_adr_o == 3'd4) begin
      rx_avail <= rx_avail - 1;
      rx_byte  <= rx_byte + 8'd1;
    end
  end
  assign wb_bus.wb_dat_i = {24'hA5C3E1, rx_byte};
  assign rx_int = (rx_avail != 0);

  // Scoreboard monitors, sampled on the falling edge.
  int   cyc_cnt = 0, last_ack_cyc = 0, last_gap = 0;
  int   n_acc = 0, n_rd = 0, n_err = 0;
  logic cyc_prev = 1'b0;

  always @(negedge clk) begin
    bus_t e;
    logic [7:0] r;
    cyc_cnt++;
    if (wb_bus.wb_cyc_o && !cyc_prev) begin
      n_acc++;
      last_gap = cyc_cnt - last_ack_cyc - 1;
    end
    cyc_prev = wb_bus.wb_cyc_o;
    if (err) n_err++;
    if (wb_bus.wb_cyc_o && wb_bus.wb_stb_o && wb_bus.wb_ack_i) begin
      last_ack_cyc = cyc_cnt;
      if (!wb_bus.wb_we_o) n_rd++;
      chk("bus_expected", exp_bus_q.size() != 0, 1);
      if (exp_bus_q.size() != 0) begin
        e = exp_bus_q.pop_front();
        if (e.we)
          chk("bus_wr", {wb_bus.wb_we_o, wb_bus.wb_adr_o, wb_bus.wb_dat_o}, e);
        else
          chk("bus_rd", {wb_bus.wb_we_o, wb_bus.wb_adr_o}, {e.we, e.adr});
      end
      $display("bus: we=%0d adr=%0d dat_o=%0h dat_i=%0h", wb_bus.wb_we_o,
               wb_bus.wb_adr_o, wb_bus.wb_dat_o, wb_bus.wb_dat_i);
    end
    if (rx_tvalid && rx_tready) begin
      chk("rx_expected", exp_rx_q.size() != 0, 1);
      if (exp_rx_q.size() != 0) begin
        r = exp_rx_q.pop_front();
        chk("rx_byte", rx_tdata, r);
      end
      $display("rx: byte=%0h", rx_tdata);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bus_t wr(input logic [2:0] a, input logic [31:0] d);
    wr = '{we: 1'b1, adr: a, dat: d};
  endfunction

  function automatic bus_t rd();
    rd = '{we: 1'b0, adr: 3'd4, dat: 32'd0};
  endfunction

  task automatic rx_set(input int v);
    rx_set_val = v;
    rx_set_stb = 1'b1;
    tick(1);
    rx_set_stb = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    logic ok;
    ok = 1'b0;
    tx_tdata  = b;
    tx_tvalid = 1'b1;
    for (k = 0; k < 200 && !ok; k++) begin
      ok = tx_tready;
      tick(1);
    end
    tx_tvalid = 1'b0;
    chk("tx_accept_in_time", ok, 1);
    chk("tx_tready_low_after_accept", tx_tready, 0);
    $display("tx: sent byte=%0h", b);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (k < 400 && (exp_bus_q.size() != 0 || exp_rx_q.size() != 0 || wb_bus.wb_cyc_o)) begin
      tick(1);
      k++;
    end
    chk({"idle_", tag}, k < 400, 1);
    tick(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, acc0, err0, cnt, k;

    // Reset values
    tick(3);
    chk("rst_wb", {wb_bus.wb_cyc_o, wb_bus.wb_stb_o, wb_bus.wb_we_o, wb_bus.wb_adr_o, wb_bus.wb_dat_o}, 0);
    chk("rst_streams", {tx_tready, rx_tvalid, rx_tdata}, 0);
    chk("rst_busy", busy, 1);
    chk("rst_err", err, 0);

    // INIT_DIV after release: one write adr 0, busy falls on cycle 4
    exp_bus_q.push_back(wr(3'd0, {16'd0, P_CLKDIV}));
    rst = 1'b0;
    tick(1);
    chk("init_cyc_up", {wb_bus.wb_cyc_o, wb_bus.wb_stb_o, wb_bus.wb_adr_o}, {1'b1, 1'b1, 3'd0});
    tick(1);
    chk("init_busy_cycle3", busy, 1);
    tick(1);
    chk("init_busy_cycle4", busy, 0);
    wait_idle("init");

    // Two back-to-back TX bytes separated by SETTLE+1 idle cycles
    tx_int = 1'b1;
    exp_bus_q.push_back(wr(3'd3, 32'h41));
    exp_bus_q.push_back(wr(3'd3, 32'h42));
    send_byte(8'h41);
    send_byte(8'h42);
    wait_idle("tx");
    chk("tx_gap", last_gap, P_SETTLE + 1);

    // RX: one read while the consumer stalls, next only after handshake
    rd0 = n_rd;
    exp_bus_q.push_back(rd());
    exp_bus_q.push_back(rd());
    exp_rx_q.push_back(8'h5A);
    exp_rx_q.push_back(8'h5B);
    rx_set(2);
    tick(20);
    chk("rx_tvalid_held", rx_tvalid, 1);
    chk("rx_tdata_held", rx_tdata, 8'h5A);
    chk("rx_single_read", n_rd - rd0, 1);
    rx_tready = 1'b1;
    wait_idle("rx");
    chk("rx_two_reads", n_rd - rd0, 2);

    // Held TX byte with tx_int low: no bus activity
    tx_int = 1'b0;
    acc0 = n_acc;
    send_byte(8'h55);
    tick(10);
    chk("no_bus_tx_int_low", n_acc - acc0, 0);
    chk("tx_tready_while_held", tx_tready, 0);
    chk("busy_while_held", busy, 1);

    // Round robin TX/RX, divider request mid TXCHAR write
    exp_bus_q.push_back(wr(3'd3, 32'h55));
    exp_bus_q.push_back(rd());
    exp_bus_q.push_back(wr(3'd3, 32'h66));
    exp_bus_q.push_back(wr(3'd0, 32'd100));
    exp_bus_q.push_back(rd());
    exp_rx_q.push_back(8'h5C);
    exp_rx_q.push_back(8'h5D);
    rx_set(2);
    tx_int = 1'b1;
    send_byte(8'h66);
    k = 0;
    while (k < 100 && !(wb_bus.wb_cyc_o && wb_bus.wb_we_o && wb_bus.wb_adr_o == 3'd3)) begin
      tick(1);
      k++;
    end
    chk("tx66_started", k < 100, 1);
    clkdiv = 16'd100;
    clkdiv_stb = 1'b1;
    tick(1);
    clkdiv_stb = 1'b0;
    wait_idle("rr_div");

    // Timeout on TXCHAR, then retry
    ack_en = 1'b0;
    err0 = n_err;
    send_byte(8'h77);
    k = 0;
    while (k < 50 && !wb_bus.wb_stb_o) begin
      tick(1);
      k++;
    end
    chk("tmo_stb_seen", k < 50, 1);
    cnt = 0;
    while (cnt < 100 && wb_bus.wb_stb_o) begin
      tick(1);
      cnt++;
    end
    chk("tmo_stb_cycles", cnt, P_TMO);
    chk("tmo_err_pulse", err, 1);
    chk("tmo_byte_held", tx_tready, 0);
    ack_en = 1'b1;
    exp_bus_q.push_back(wr(3'd3, 32'h77));
    wait_idle("tmo_retry");
    chk("tmo_err_count", n_err - err0, 1);

    // Reset during an RX read, INIT_DIV reruns
    ack_en = 1'b0;
    rx_tready = 1'b0;
    rx_set(1);
    k = 0;
    while (k < 50 && !(wb_bus.wb_cyc_o && wb_bus.wb_adr_o == 3'd4)) begin
      tick(1);
      k++;
    end
    chk("rd_started", k < 50, 1);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_cyc", {wb_bus.wb_cyc_o, wb_bus.wb_stb_o}, 0);
    chk("rst_mid_rx_tvalid", rx_tvalid, 0);
    chk("rst_mid_busy", busy, 1);
    chk("rst_mid_tx_tready", tx_tready, 0);
    rx_set(0);
    acc0 = n_acc;
    exp_bus_q.push_back(wr(3'd0, {16'd0, P_CLKDIV}));
    ack_en = 1'b1;
    rst = 1'b0;
    wait_idle("reinit");
    chk("reinit_accesses", n_acc - acc0, 1);
    chk("reinit_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
